ym6045c_cell_shreg_n: RTL and testbench

Parametrised N-bit shift register. It is the successor to the fixed 8-bit shift-register cell and serves the arbiter's serial and timing paths.
- Adds parallel load, left/right direction and rotate-or-serial-fill mode.
- Adds a programmable shift count with busy/done handshake and a selectable tap output, which replaces hard-wired tap cells.
- Sits beside the counter and delay cells as a reusable sequential primitive.

---
 rtl/ym6045c_pkg.sv | 19 +
 rtl/ym6045c_cell_shreg_ctl.sv | 85 ++++++++
 rtl/ym6045c_cell_shreg_n.sv | 94 +++++++++
 tb/tb_ym6045c_cell_shreg_n.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ym6045c_pkg.sv
// Shared types and constants for the ym6045c sequential cell library.
package ym6045c_pkg;

    typedef enum logic [1:0] {
        SHREG_IDLE  = 2'd0,
        SHREG_SHIFT = 2'd1,
        SHREG_DONE  = 2'd2
    } shreg_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Shift-run configuration captured at start.
    typedef struct packed {
        logic dir;
        logic rot;
    } shreg_cfg_t;

endpackage

// File: rtl/ym6045c_cell_shreg_ctl.sv
// Shift-run controller: FSM, remaining-shift counter and captured dir/rot.
module ym6045c_cell_shreg_ctl
    import ym6045c_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             dir_i,
    input  logic             rot_i,
    output logic             shift_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             dir_o,
    output logic             rot_o
);

    shreg_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    shreg_cfg_t       cfg_q, cfg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHREG_IDLE;
            cnt_q   <= '0;
            cfg_q   <= '{dir: DIR_LEFT, rot: 1'b0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        unique case (state_q)
            SHREG_IDLE, SHREG_DONE: begin
                state_d = SHREG_IDLE;
                if (start_i) begin
                    if (count_i != '0) begin
                        state_d = SHREG_SHIFT;
                        cnt_d   = count_i;
                        cfg_d   = '{dir: dir_i, rot: rot_i};
                    end else begin
                        state_d = SHREG_DONE;
                    end
                end
            end
            SHREG_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SHREG_DONE;
                end
            end
            default: state_d = SHREG_IDLE;
        endcase
    end

    // Output decode of the upcoming state.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == SHREG_SHIFT);
        done_d = (state_d == SHREG_DONE);
    end

    assign shift_en_o = busy_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign dir_o      = cfg_q.dir;
    assign rot_o      = cfg_q.rot;

endmodule

// File: rtl/ym6045c_cell_shreg_n.sv
// Parametrised N-bit shift register with parallel load, rotate/fill,
// programmable shift count with busy/done handshake and a selectable tap.
module ym6045c_cell_shreg_n
    import ym6045c_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 4,
    parameter int unsigned      SEL_W     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             dir_i,
    input  logic             rot_i,
    input  logic             ser_i,
    input  logic [SEL_W-1:0] tap_sel_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_o,
    output logic             tap_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned TAP_N = 1 << SEL_W;

    logic             shift_en;
    logic             busy;
    logic             dir_lat;
    logic             rot_lat;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shifted;
    logic             fill;
    logic [TAP_N-1:0] tap_vec;

    ym6045c_cell_shreg_ctl #(
        .CNT_W (CNT_W)
    ) u_ctl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .count_i    (count_i),
        .dir_i      (dir_i),
        .rot_i      (rot_i),
        .shift_en_o (shift_en),
        .busy_o     (busy),
        .done_o     (done_o),
        .dir_o      (dir_lat),
        .rot_o      (rot_lat)
    );

    // Single-bit shift using the captured direction and fill mode.
    always_comb begin
        fill    = 1'b0;
        shifted = q_q;
        if (dir_lat == DIR_RIGHT) begin
            fill    = rot_lat ? q_q[0] : ser_i;
            shifted = {fill, q_q[WIDTH-1:1]};
        end else begin
            fill    = rot_lat ? q_q[WIDTH-1] : ser_i;
            shifted = {q_q[WIDTH-2:0], fill};
        end
    end

    // Load is only honoured outside a run.
    always_comb begin
        q_d = q_q;
        if (load_i && !busy) begin
            q_d = load_data_i;
        end else if (shift_en) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Zero-extended view so out-of-range tap indices read as 0.
    assign tap_vec = TAP_N'(q_q);
    assign tap_o   = tap_vec[tap_sel_i];

    assign q_o    = q_q;
    assign ser_o  = (dir_lat == DIR_RIGHT) ? q_q[0] : q_q[WIDTH-1];
    assign busy_o = busy;

endmodule

// File: tb/tb_ym6045c_cell_shreg_n.sv
// Self-checking bench for ym6045c_cell_shreg_n: vector table plus handshake,
// reset-abort and tap sequences, with a scoreboard of expected final values.
module tb_ym6045c_cell_shreg_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_i;
    logic [7:0] load_data_i;
    logic       start_i;
    logic [3:0] count_i;
    logic       dir_i;
    logic       rot_i;
    logic       ser_i;
    logic [2:0] tap_sel_i;
    logic [7:0] q_o;
    logic       ser_o;
    logic       tap_o;
    logic       busy_o;
    logic       done_o;

    logic       b_load_i;
    logic [5:0] b_load_data_i;
    logic       b_start_i;
    logic [3:0] b_count_i;
    logic       b_dir_i;
    logic       b_rot_i;
    logic       b_ser_i;
    logic [2:0] b_tap_sel_i;
    logic [5:0] b_q_o;
    logic       b_ser_o;
    logic       b_tap_o;
    logic       b_busy_o;
    logic       b_done_o;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    ym6045c_cell_shreg_n #(
        .WIDTH(8), .CNT_W(4), .SEL_W(3), .RESET_VAL(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .load_data_i(load_data_i),
        .start_i(start_i), .count_i(count_i), .dir_i(dir_i), .rot_i(rot_i),
        .ser_i(ser_i), .tap_sel_i(tap_sel_i), .q_o(q_o), .ser_o(ser_o),
        .tap_o(tap_o), .busy_o(busy_o), .done_o(done_o)
    );

    ym6045c_cell_shreg_n #(
        .WIDTH(6), .CNT_W(4), .SEL_W(3), .RESET_VAL(6'h00)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .load_i(b_load_i), .load_data_i(b_load_data_i),
        .start_i(b_start_i), .count_i(b_count_i), .dir_i(b_dir_i), .rot_i(b_rot_i),
        .ser_i(b_ser_i), .tap_sel_i(b_tap_sel_i), .q_o(b_q_o), .ser_o(b_ser_o),
        .tap_o(b_tap_o), .busy_o(b_busy_o), .done_o(b_done_o)
    );

    typedef struct {
        logic [7:0]  ld;
        logic [3:0]  cnt;
        logic        dir;
        logic        rot;
        logic        ser;
        logic [7:0]  exp_q;
        int          exp_busy;
        logic [15:0] exp_hist;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string nm);
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, "_q"}, 32'(q_o), 32'(e));
        end
    endtask

    // Load and start on the same edge, then follow the run to done.
    task automatic run_vec(input vec_t v, input string nm);
        int          busy_cnt;
        int          guard;
        logic [15:0] hist;
        load_i      = 1'b1;
        load_data_i = v.ld;
        start_i     = 1'b1;
        count_i     = v.cnt;
        dir_i       = v.dir;
        rot_i       = v.rot;
        ser_i       = v.ser;
        sb.push_back(v.exp_q);
        tick();
        load_i   = 1'b0;
        start_i  = 1'b0;
        busy_cnt = 0;
        guard    = 0;
        hist     = '0;
        while (!done_o && guard < 40) begin
            if (busy_o) begin
                busy_cnt++;
                hist = {hist[14:0], ser_o};
            end
            tick();
            guard++;
        end
        if (!done_o) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            pop_chk(nm);
            chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
            chk({nm, "_ser_hist"}, 32'(hist), 32'(v.exp_hist));
            chk({nm, "_busy_in_done"}, 32'(busy_o), 32'd0);
            tick();
            chk({nm, "_done_pulse"}, 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{8'h81, 4'd3,  1'b0, 1'b1, 1'b0, 8'h0C, 3,  16'h0004};
        vecs[1] = '{8'hF0, 4'd4,  1'b1, 1'b0, 1'b1, 8'hFF, 4,  16'h0000};
        vecs[2] = '{8'h3C, 4'd8,  1'b0, 1'b1, 1'b0, 8'h3C, 8,  16'h003C};
        vecs[3] = '{8'h3C, 4'd8,  1'b1, 1'b1, 1'b0, 8'h3C, 8,  16'h003C};
        vecs[4] = '{8'h12, 4'd1,  1'b0, 1'b0, 1'b0, 8'h24, 1,  16'h0000};
        vecs[5] = '{8'hA5, 4'd0,  1'b0, 1'b0, 1'b0, 8'hA5, 0,  16'h0000};
        vecs[6] = '{8'h01, 4'd15, 1'b1, 1'b1, 1'b0, 8'h02, 15, 16'h4040};
        vecs[7] = '{8'h00, 4'd5,  1'b0, 1'b0, 1'b1, 8'h1F, 5,  16'h0000};

        rst_n = 1'b0;
        load_i = 1'b0; load_data_i = '0; start_i = 1'b0; count_i = '0;
        dir_i = 1'b0; rot_i = 1'b0; ser_i = 1'b0; tap_sel_i = '0;
        b_load_i = 1'b0; b_load_data_i = '0; b_start_i = 1'b0; b_count_i = '0;
        b_dir_i = 1'b0; b_rot_i = 1'b0; b_ser_i = 1'b0; b_tap_sel_i = '0;

        // Reset state
        tick();
        tick();
        chk("rst_q", 32'(q_o), 32'hA5);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ser_msb", 32'(ser_o), 32'd1);
        chk("rst_q6", 32'(b_q_o), 32'h00);
        rst_n = 1'b1;
        tick();
        chk("post_rst_q", 32'(q_o), 32'hA5);
        chk("post_rst_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Load/start during SHIFT are ignored, as are dir/rot changes.
        load_i = 1'b1; load_data_i = 8'h81; start_i = 1'b1;
        count_i = 4'd3; dir_i = 1'b0; rot_i = 1'b1; ser_i = 1'b0;
        sb.push_back(8'h0C);
        tick();
        load_i = 1'b1; load_data_i = 8'hFF; start_i = 1'b1;
        count_i = 4'd1; dir_i = 1'b1; rot_i = 1'b0;
        tick();
        tick();
        load_i = 1'b0; start_i = 1'b0;
        chk("hs_busy3", 32'(busy_o), 32'd1);
        chk("hs_q_mid", 32'(q_o), 32'h06);
        tick();
        chk("hs_done", 32'(done_o), 32'd1);
        pop_chk("hs_run1");
        // Start accepted in the DONE cycle.
        start_i = 1'b1; count_i = 4'd2; dir_i = 1'b1; rot_i = 1'b1;
        sb.push_back(8'h03);
        tick();
        start_i = 1'b0;
        chk("b2b_busy", 32'(busy_o), 32'd1);
        chk("b2b_done_low", 32'(done_o), 32'd0);
        tick();
        tick();
        chk("b2b_done", 32'(done_o), 32'd1);
        pop_chk("b2b_run2");
        tick();
        chk("b2b_done_pulse", 32'(done_o), 32'd0);

        // Reset mid-run aborts without a done pulse.
        load_i = 1'b1; load_data_i = 8'h0F; start_i = 1'b1;
        count_i = 4'd5; dir_i = 1'b0; rot_i = 1'b0; ser_i = 1'b1;
        tick();
        load_i = 1'b0; start_i = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_q", 32'(q_o), 32'hA5);
        chk("abort_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("abort_hold_done%0d", i), 32'(done_o), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort_after_done%0d", i), 32'(done_o), 32'd0);
        end
        chk("abort_after_q", 32'(q_o), 32'hA5);

        // Tap selection
        load_i = 1'b1; load_data_i = 8'h40;
        b_load_i = 1'b1; b_load_data_i = 6'h2A;
        tick();
        load_i = 1'b0; b_load_i = 1'b0;
        tap_sel_i = 3'd6;
        #1;
        chk("tap8_sel6", 32'(tap_o), 32'd1);
        tap_sel_i = 3'd5;
        #1;
        chk("tap8_sel5", 32'(tap_o), 32'd0);
        b_tap_sel_i = 3'd7;
        #1;
        chk("tap6_sel7", 32'(b_tap_o), 32'd0);
        b_tap_sel_i = 3'd6;
        #1;
        chk("tap6_sel6", 32'(b_tap_o), 32'd0);
        b_tap_sel_i = 3'd5;
        #1;
        chk("tap6_sel5", 32'(b_tap_o), 32'd1);
        b_tap_sel_i = 3'd0;
        #1;
        chk("tap6_sel0", 32'(b_tap_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
